// File: rtl/fp_cvt_d_int_pipe.sv
// rtl/fp_cvt_d_int_pipe.sv - pipelined FCVT.D.{W,WU,L,LU}: 3 stages, global stall, all static rounding modes.
// Optional passthrough tag enabled by defining FP_CVT_TAG_EN.
module fp_cvt_d_int_pipe #(
    parameter int INT_W = 64
`ifdef FP_CVT_TAG_EN
    ,
    parameter int TAG_W = 5
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INT_W-1:0] in_int,
    input  logic             in_signed,
    input  logic [2:0]       in_rm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_d,
    output logic             out_nx
`ifdef FP_CVT_TAG_EN
    ,
    input  logic [TAG_W-1:0] in_tag,
    output logic [TAG_W-1:0] out_tag
`endif
);

    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // S1: sign and two's-complement magnitude (most negative value maps exactly)
    logic             in_neg;
    logic             s1_valid, s1_sign;
    logic [INT_W-1:0] s1_abs;
    logic [2:0]       s1_rm;

    assign in_neg = in_signed & in_int[INT_W-1];

    always_ff @(posedge clk) begin
        if (rst) s1_valid <= 1'b0;
        else if (adv) s1_valid <= in_valid;
        if (adv) begin
            s1_sign <= in_neg;
            s1_abs  <= in_neg ? -in_int : in_int;
            s1_rm   <= in_rm;
        end
    end

    // S2: leading-zero count over a 64-bit view, then left-normalise so the MSB sits at bit 63
    logic [63:0] s1_ext, s1_norm;
    logic [5:0]  s1_lz;
    logic        s1_zero;

    always_comb begin
        s1_ext = 64'(s1_abs);
        s1_lz  = 6'd0;
        for (int i = 0; i < 64; i++) begin
            if (s1_ext[i]) s1_lz = 6'(63 - i);
        end
        s1_norm = s1_ext << s1_lz;
        s1_zero = (s1_abs == '0);
    end

    logic        s2_valid, s2_sign, s2_zero;
    logic [10:0] s2_exp;
    logic [63:0] s2_mant;
    logic [2:0]  s2_rm;

    always_ff @(posedge clk) begin
        if (rst) s2_valid <= 1'b0;
        else if (adv) s2_valid <= s1_valid;
        if (adv) begin
            s2_sign <= s1_sign;
            s2_zero <= s1_zero;
            s2_exp  <= 11'd1086 - {5'd0, s1_lz};
            s2_mant <= s1_norm;
            s2_rm   <= s1_rm;
        end
    end

    // S3: bits below mantissa position 11 are dropped; they are all zero when msb <= 52
    logic        grd, sticky, lsb, inc;
    logic [52:0] frac_sum;
    logic [10:0] res_exp;
    logic [63:0] res_d;
    logic        res_nx;

    always_comb begin
        grd    = s2_mant[10];
        sticky = |s2_mant[9:0];
        lsb    = s2_mant[11];
        case (s2_rm)
            3'b001:  inc = 1'b0;
            3'b010:  inc = s2_sign & (grd | sticky);
            3'b011:  inc = ~s2_sign & (grd | sticky);
            3'b100:  inc = grd;
            default: inc = grd & (sticky | lsb);
        endcase
        frac_sum = {1'b0, s2_mant[62:11]} + 53'(inc);
        // carry-out leaves the fraction field at zero, so only the exponent moves
        res_exp  = s2_exp + {10'd0, frac_sum[52]};
        res_d    = s2_zero ? 64'd0 : {s2_sign, res_exp, frac_sum[51:0]};
        res_nx   = ~s2_zero & (grd | sticky);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_d     <= 64'd0;
            out_nx    <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            out_d     <= res_d;
            out_nx    <= res_nx;
        end
    end

`ifdef FP_CVT_TAG_EN
    logic [TAG_W-1:0] s1_tag, s2_tag;

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_tag <= in_tag;
            s2_tag <= s1_tag;
        end
        if (rst) out_tag <= '0;
        else if (adv) out_tag <= s2_tag;
    end
`endif

endmodule
